// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode enum and pointer-width helper.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Pointers carry one extra wrap bit above the storage address.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Register-array storage: synchronous write, asynchronous read, no reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int BUFFER_DEPTH = 16
) (
  input  logic                                  clk_i,
  input  logic                                  we,
  input  logic [fifo_ptr_w(BUFFER_DEPTH)-2:0]   waddr,
  input  logic [DATA_WIDTH-1:0]                 wdata,
  input  logic [fifo_ptr_w(BUFFER_DEPTH)-2:0]   raddr,
  output logic [DATA_WIDTH-1:0]                 rdata
);

  logic [BUFFER_DEPTH-1:0][DATA_WIDTH-1:0] mem;

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock circular-buffer FIFO with selectable standard/FWFT read,
// occupancy count, almost-full/empty thresholds and sticky error flags.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int BUFFER_DEPTH  = 16,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = BUFFER_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 we_i,
  input  logic [DATA_WIDTH-1:0]                din_i,
  output logic                                 wrdy_o,
  output logic                                 afull_o,
  input  logic                                 re_i,
  output logic [DATA_WIDTH-1:0]                dout_o,
  output logic                                 rrdy_o,
  output logic                                 aempty_o,
  output logic [$clog2(BUFFER_DEPTH):0]        count_o,
  input  logic                                 clr_flags_i,
  output logic                                 ovf_o,
  output logic                                 udf_o
);

  localparam int PW = fifo_ptr_w(BUFFER_DEPTH);
  localparam int AW = PW - 1;
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [31:0] AF_T = 32'(AFULL_THRESH);
  localparam logic [31:0] AE_T = 32'(AEMPTY_THRESH);

  logic [PW-1:0]         wr_ptr, rd_ptr, cnt;
  logic                  full, empty, wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] rdata;

  // Status is decoded purely from the registered pointers.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cnt    = wr_ptr - rd_ptr;
  assign wr_acc = we_i && !full;
  assign rd_acc = re_i && !empty;

  assign wrdy_o   = !full;
  assign rrdy_o   = !empty;
  assign count_o  = cnt;
  assign afull_o  = (32'(cnt) >= AF_T);
  assign aempty_o = (32'(cnt) <= AE_T);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // A fresh error in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_o <= 1'b0;
      udf_o <= 1'b0;
    end else begin
      if (we_i && full)       ovf_o <= 1'b1;
      else if (clr_flags_i)   ovf_o <= 1'b0;
      if (re_i && empty)      udf_o <= 1'b1;
      else if (clr_flags_i)   udf_o <= 1'b0;
    end
  end

  fifo_ram #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BUFFER_DEPTH(BUFFER_DEPTH)
  ) u_ram (
    .clk_i(clk_i),
    .we   (wr_acc),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(din_i),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rdata)
  );

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      assign dout_o = rrdy_o ? rdata : '0;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] dout_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)       dout_q <= '0;
        else if (rd_acc) dout_q <= rdata;
      end
      assign dout_o = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives a standard-mode and an FWFT-mode FIFO with identical stimulus;
// read data is checked by a queue-based monitor, status by directed checks.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst, we, re, clr;
  logic [7:0] din;

  logic       s_wrdy, s_afull, s_rrdy, s_aempty, s_ovf, s_udf;
  logic [7:0] s_dout;
  logic [4:0] s_count;
  logic       f_wrdy, f_afull, f_rrdy, f_aempty, f_ovf, f_udf;
  logic [7:0] f_dout;
  logic [4:0] f_count;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_s[$];
  logic [7:0] exp_f[$];

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(8), .BUFFER_DEPTH(16), .FWFT(0)) dut_s (
    .clk_i(clk), .rst_i(rst), .we_i(we), .din_i(din), .wrdy_o(s_wrdy),
    .afull_o(s_afull), .re_i(re), .dout_o(s_dout), .rrdy_o(s_rrdy),
    .aempty_o(s_aempty), .count_o(s_count), .clr_flags_i(clr),
    .ovf_o(s_ovf), .udf_o(s_udf)
  );

  sync_fifo_param #(.DATA_WIDTH(8), .BUFFER_DEPTH(16), .FWFT(1)) dut_f (
    .clk_i(clk), .rst_i(rst), .we_i(we), .din_i(din), .wrdy_o(f_wrdy),
    .afull_o(f_afull), .re_i(re), .dout_o(f_dout), .rrdy_o(f_rrdy),
    .aempty_o(f_aempty), .count_o(f_count), .clr_flags_i(clr),
    .ovf_o(f_ovf), .udf_o(f_udf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    exp_s.push_back(v);
    exp_f.push_back(v);
  endtask

  // Monitor: a read is presented when re && rrdy at the edge. FWFT data is
  // the word shown before the edge; standard data appears after it.
  always begin
    logic s_pop, f_pop;
    logic [7:0] f_word, e;
    @(negedge clk);
    s_pop  = re && s_rrdy && !rst;
    f_pop  = re && f_rrdy && !rst;
    f_word = f_dout;
    @(posedge clk);
    #2;
    if (s_pop) begin
      if (exp_s.size() == 0) chk("std_queue_empty", 1, 0);
      else begin e = exp_s.pop_front(); chk("std_dout", {24'h0, s_dout}, {24'h0, e}); end
    end
    if (f_pop) begin
      if (exp_f.size() == 0) chk("fwft_queue_empty", 1, 0);
      else begin e = exp_f.pop_front(); chk("fwft_dout", {24'h0, f_word}, {24'h0, e}); end
    end
  end

  task automatic chk_reset_state();
    chk("rst_count",  {27'h0, s_count}, 0);
    chk("rst_wrdy",   {31'h0, s_wrdy}, 1);
    chk("rst_rrdy",   {31'h0, s_rrdy}, 0);
    chk("rst_aempty", {31'h0, s_aempty}, 1);
    chk("rst_afull",  {31'h0, s_afull}, 0);
    chk("rst_dout",   {24'h0, s_dout}, 0);
    chk("rst_ovf",    {31'h0, s_ovf}, 0);
    chk("rst_udf",    {31'h0, s_udf}, 0);
    chk("rst_fdout",  {24'h0, f_dout}, 0);
    chk("rst_fcount", {27'h0, f_count}, 0);
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; clr = 1'b0; din = 8'h00;
    #1;
    chk_reset_state();
    step(); step();
    rst = 1'b0;

    // Fill 0x01..0x10
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; din = 8'(i + 1);
      step();
      chk("fill_count", {27'h0, s_count}, i + 1);
      chk("fill_afull", {31'h0, s_afull}, (i + 1 >= 14) ? 1 : 0);
      chk("fill_aempty", {31'h0, s_aempty}, (i + 1 <= 2) ? 1 : 0);
      chk("fill_wrdy", {31'h0, s_wrdy}, (i + 1 < 16) ? 1 : 0);
      if (i == 0) chk("fwft_first_word", {24'h0, f_dout}, 32'h01);
    end
    din = 8'h77;
    step();
    we = 1'b0;
    chk("ovf_on_full", {31'h0, s_ovf}, 1);
    chk("count_stays_16", {27'h0, s_count}, 16);
    chk("fwft_ovf", {31'h0, f_ovf}, 1);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      re = 1'b1; push(8'(i + 1));
      step();
      chk("drain_count", {27'h0, s_count}, 15 - i);
      chk("drain_rrdy", {31'h0, s_rrdy}, (i < 15) ? 1 : 0);
    end
    step();
    re = 1'b0;
    chk("udf_on_empty", {31'h0, s_udf}, 1);
    chk("dout_holds", {24'h0, s_dout}, 32'h10);

    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_ovf", {31'h0, s_ovf}, 0);
    chk("clr_udf", {31'h0, s_udf}, 0);

    // FWFT fall-through of a single word
    we = 1'b1; din = 8'hA5; step(); we = 1'b0;
    chk("fwft_rrdy", {31'h0, f_rrdy}, 1);
    chk("fwft_show", {24'h0, f_dout}, 32'hA5);
    re = 1'b1; push(8'hA5); step(); re = 1'b0;
    chk("fwft_rrdy_after_pop", {31'h0, f_rrdy}, 0);
    chk("fwft_dout_zero", {24'h0, f_dout}, 0);

    // Steady state at count 5 across pointer wrap
    for (int i = 0; i < 5; i++) begin
      we = 1'b1; din = 8'(8'h20 + i); step();
    end
    for (int i = 0; i < 40; i++) begin
      we = 1'b1; re = 1'b1; din = 8'(8'h25 + i); push(8'(8'h20 + i));
      step();
      chk("steady_count", {27'h0, s_count}, 5);
    end
    we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      re = 1'b1; push(8'(8'h48 + i)); step();
    end
    re = 1'b0;
    chk("steady_drained", {27'h0, s_count}, 0);

    // Simultaneous at full: read wins, write dropped
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; din = 8'(8'h80 + i); step();
    end
    din = 8'hEE; re = 1'b1; push(8'h80);
    step();
    we = 1'b0; re = 1'b0;
    chk("full_rw_count", {27'h0, s_count}, 15);
    chk("full_rw_ovf", {31'h0, s_ovf}, 1);
    clr = 1'b1; step(); clr = 1'b0;
    for (int i = 1; i < 16; i++) begin
      re = 1'b1; push(8'(8'h80 + i)); step();
    end
    re = 1'b0;
    chk("full_rw_drained", {27'h0, s_count}, 0);

    // Simultaneous at empty: write accepted, read rejected
    we = 1'b1; re = 1'b1; din = 8'h3C; step();
    we = 1'b0; re = 1'b0;
    chk("empty_rw_count", {27'h0, s_count}, 1);
    chk("empty_rw_udf", {31'h0, s_udf}, 1);
    re = 1'b1; push(8'h3C); step(); re = 1'b0;

    // Clear racing a new overflow
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; din = 8'(8'h90 + i); step();
    end
    clr = 1'b1; step();
    we = 1'b0;
    chk("clr_vs_ovf_set_wins", {31'h0, s_ovf}, 1);
    chk("clr_udf_same_cycle", {31'h0, s_udf}, 0);
    step(); clr = 1'b0;
    chk("clr_ovf_after", {31'h0, s_ovf}, 0);

    // Async reset at count 7
    for (int i = 0; i < 9; i++) begin
      re = 1'b1; push(8'(8'h90 + i)); step();
    end
    re = 1'b0;
    chk("pre_reset_count", {27'h0, s_count}, 7);
    #2 rst = 1'b1;
    #1;
    chk_reset_state();
    step();
    rst = 1'b0;
    we = 1'b1; din = 8'h5A; step(); we = 1'b0;
    chk("post_reset_count", {27'h0, s_count}, 1);
    chk("post_reset_fwft", {24'h0, f_dout}, 32'h5A);
    re = 1'b1; push(8'h5A); step(); re = 1'b0;

    for (int i = 0; i < 20 && (exp_s.size() != 0 || exp_f.size() != 0); i++) step();
    chk("std_queue_left", exp_s.size(), 0);
    chk("fwft_queue_left", exp_f.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
